// File: rtl/mandelbrot_engine.sv
// mandelbrot_engine: iterates z <= z^2 + c in signed fixed point (Q(W-F).F)
// until |z|^2 >= 4.0 or the iteration limit is reached, then holds the
// result (in_set, iterations) behind a valid/ready handshake.
// Optional feature macro: MANDEL_JULIA_EN adds z_real_in / z_imag_in so the
// starting z is supplied with the job (Julia mode); without it z starts at 0.
module mandelbrot_engine #(
    parameter int FIXED_POINT_WIDTH = 16,
    parameter int FRAC_BITS         = 12,
    parameter int ITER_WIDTH        = 8
) (
    input  logic                                clk,
    input  logic                                nrst,
    input  logic                                start,
    output logic                                start_ready,
    input  logic signed [FIXED_POINT_WIDTH-1:0] c_real_in,
    input  logic signed [FIXED_POINT_WIDTH-1:0] c_imag_in,
`ifdef MANDEL_JULIA_EN
    input  logic signed [FIXED_POINT_WIDTH-1:0] z_real_in,
    input  logic signed [FIXED_POINT_WIDTH-1:0] z_imag_in,
`endif
    input  logic [ITER_WIDTH-1:0]               max_iter_in,
    output logic                                busy,
    output logic                                res_valid,
    input  logic                                res_ready,
    output logic                                in_set,
    output logic [ITER_WIDTH-1:0]               iterations
);

    localparam int W  = FIXED_POINT_WIDTH;
    localparam int MW = 2 * FIXED_POINT_WIDTH + 1;

    // 4.0 expressed in the scale of a product of two fixed-point values
    localparam logic signed [MW-1:0] ESC_LIMIT = MW'(3'd4) << (2 * FRAC_BITS);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ITERATE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t state_r;
    state_t state_nxt_s;

    logic signed [W-1:0]     zr_r;
    logic signed [W-1:0]     zi_r;
    logic signed [W-1:0]     cr_r;
    logic signed [W-1:0]     ci_r;
    logic [ITER_WIDTH-1:0]   limit_r;
    logic [ITER_WIDTH-1:0]   count_r;
    logic                    in_set_r;
    logic [ITER_WIDTH-1:0]   iter_r;
    logic                    busy_r;
    logic                    res_valid_r;

    logic                    start_ready_s;
    logic                    accept_s;
    logic                    escape_s;
    logic                    limit_hit_s;
    logic signed [W-1:0]     z_init_re_s;
    logic signed [W-1:0]     z_init_im_s;

    // Full-precision datapath terms: operands sign-extended to the product width
    logic signed [2*W-1:0]   zr_ext_s;
    logic signed [2*W-1:0]   zi_ext_s;
    logic signed [2*W-1:0]   zr_sq_s;
    logic signed [2*W-1:0]   zi_sq_s;
    logic signed [2*W-1:0]   zrzi_s;
    logic signed [MW-1:0]    mag_s;
    logic signed [MW-1:0]    diff_s;
    logic signed [MW-1:0]    dbl_s;
    logic signed [W-1:0]     zr_nxt_s;
    logic signed [W-1:0]     zi_nxt_s;

`ifdef MANDEL_JULIA_EN
    assign z_init_re_s = z_real_in;
    assign z_init_im_s = z_imag_in;
`else
    assign z_init_re_s = {W{1'b0}};
    assign z_init_im_s = {W{1'b0}};
`endif

    assign zr_ext_s = {{W{zr_r[W-1]}}, zr_r};
    assign zi_ext_s = {{W{zi_r[W-1]}}, zi_r};
    assign zr_sq_s  = zr_ext_s * zr_ext_s;
    assign zi_sq_s  = zi_ext_s * zi_ext_s;
    assign zrzi_s   = zr_ext_s * zi_ext_s;

    // Sum and difference get one guard bit so nothing is lost before the shift
    assign mag_s    = {zr_sq_s[2*W-1], zr_sq_s} + {zi_sq_s[2*W-1], zi_sq_s};
    assign diff_s   = {zr_sq_s[2*W-1], zr_sq_s} - {zi_sq_s[2*W-1], zi_sq_s};
    assign dbl_s    = {zrzi_s, 1'b0};

    // Rescale, wrap to the value width, then add c (wrapping add)
    assign zr_nxt_s = W'(diff_s >>> FRAC_BITS) + cr_r;
    assign zi_nxt_s = W'(dbl_s >>> FRAC_BITS) + ci_r;

    assign escape_s    = (mag_s >= ESC_LIMIT);
    assign limit_hit_s = (count_r == limit_r);

    assign start_ready_s = (state_r == ST_IDLE) || ((state_r == ST_DONE) && res_ready);
    assign accept_s      = start && start_ready_s;

    assign start_ready = start_ready_s;
    assign busy        = busy_r;
    assign res_valid   = res_valid_r;
    assign in_set      = in_set_r;
    assign iterations  = iter_r;

    // Next-state decode: escape or limit ends a job; DONE waits for the consumer
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_ITERATE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ITERATE: begin
                if (escape_s || limit_hit_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_ITERATE;
                end
            end
            ST_DONE: begin
                if (res_ready && start) begin
                    state_nxt_s = ST_ITERATE;
                end else if (res_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register plus registered busy / res_valid decoded from the next state
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r     <= ST_IDLE;
            busy_r      <= 1'b0;
            res_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            busy_r      <= (state_nxt_s == ST_ITERATE);
            res_valid_r <= (state_nxt_s == ST_DONE);
        end
    end

    // Job capture, per-cycle iteration and result capture on termination
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            zr_r     <= {W{1'b0}};
            zi_r     <= {W{1'b0}};
            cr_r     <= {W{1'b0}};
            ci_r     <= {W{1'b0}};
            limit_r  <= {ITER_WIDTH{1'b0}};
            count_r  <= {ITER_WIDTH{1'b0}};
            in_set_r <= 1'b0;
            iter_r   <= {ITER_WIDTH{1'b0}};
        end else if (accept_s) begin
            zr_r    <= z_init_re_s;
            zi_r    <= z_init_im_s;
            cr_r    <= c_real_in;
            ci_r    <= c_imag_in;
            limit_r <= max_iter_in;
            count_r <= {ITER_WIDTH{1'b0}};
        end else if (state_r == ST_ITERATE) begin
            if (escape_s) begin
                in_set_r <= 1'b0;
                iter_r   <= count_r;
            end else if (limit_hit_s) begin
                in_set_r <= 1'b1;
                iter_r   <= count_r;
            end else begin
                zr_r    <= zr_nxt_s;
                zi_r    <= zi_nxt_s;
                count_r <= count_r + ITER_WIDTH'(1'b1);
            end
        end
    end

endmodule

// File: tb/tb_mandelbrot_engine.sv
// Scoreboard bench for mandelbrot_engine (W=16, F=12, ITER_WIDTH=8).
// The driver pushes the reference-model result of each accepted job; a
// monitor checks latency, result values and result stability.
module tb_mandelbrot_engine;

    logic               clk;
    logic               nrst;
    logic               start;
    logic               start_ready;
    logic signed [15:0] c_real_in;
    logic signed [15:0] c_imag_in;
    logic signed [15:0] z_real_in;
    logic signed [15:0] z_imag_in;
    logic [7:0]         max_iter_in;
    logic               busy;
    logic               res_valid;
    logic               res_ready;
    logic               in_set;
    logic [7:0]         iterations;

    mandelbrot_engine #(
        .FIXED_POINT_WIDTH(16),
        .FRAC_BITS(12),
        .ITER_WIDTH(8)
    ) dut (
        .clk(clk),
        .nrst(nrst),
        .start(start),
        .start_ready(start_ready),
        .c_real_in(c_real_in),
        .c_imag_in(c_imag_in),
`ifdef MANDEL_JULIA_EN
        .z_real_in(z_real_in),
        .z_imag_in(z_imag_in),
`endif
        .max_iter_in(max_iter_in),
        .busy(busy),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .in_set(in_set),
        .iterations(iterations)
    );

    typedef struct {
        int iters;
        bit ins;
        int acc;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint wrap16(input longint x);
        longint m;
        m = x & 64'hFFFF;
        if (m >= 32768) m = m - 65536;
        return m;
    endfunction

    // Reference: plain Mandelbrot/Julia escape-time iteration on integers scaled by 4096
    function automatic void ref_model(input longint cr, input longint ci, input longint zr0,
                                      input longint zi0, input int lim,
                                      output int iters, output bit ins);
        longint zr, zi, nr, ni;
        longint four;
        int     n;
        bit     done;
        four = 4 * 4096 * 4096;
        zr = zr0; zi = zi0; n = 0; done = 0; iters = 0; ins = 0;
        while (!done) begin
            if (zr * zr + zi * zi >= four) begin
                ins = 0; iters = n; done = 1;
            end else if (n == lim) begin
                ins = 1; iters = n; done = 1;
            end else begin
                nr = wrap16(((zr * zr - zi * zi) >>> 12) + cr);
                ni = wrap16(((2 * zr * zi) >>> 12) + ci);
                zr = nr; zi = ni; n++;
            end
        end
    endfunction

    // Offer one job until accepted; push the model result at the accept edge
    task automatic issue(input int cr, input int ci, input int lim, input int zr, input int zi,
                         input bit force_rr);
        exp_t e;
        bit   ok;
        int   zr0, zi0;
`ifdef MANDEL_JULIA_EN
        zr0 = zr; zi0 = zi;
`else
        zr0 = 0; zi0 = 0;
`endif
        @(negedge clk);
        c_real_in   = 16'(cr);
        c_imag_in   = 16'(ci);
        z_real_in   = 16'(zr);
        z_imag_in   = 16'(zi);
        max_iter_in = 8'(lim);
        start       = 1'b1;
        ok = 0;
        for (int n = 0; n < 3000 && !ok; n++) begin
            if (n > 0) @(negedge clk);
            res_ready = force_rr ? 1'b1 : ($urandom_range(0, 3) != 0);
            #1;
            if (start_ready) begin
                ref_model(cr, ci, zr0, zi0, lim, e.iters, e.ins);
                e.acc = cyc + 1;
                q.push_back(e);
                ok = 1;
            end
        end
        if (!ok) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 5000 && q.size() != 0; n++) begin
            @(negedge clk);
            res_ready = 1'b1;
        end
        chk("drain_timeout", q.size(), 0);
    endtask

    // Monitor: latency on the rising edge of res_valid, values every valid cycle
    initial begin : monitor
        bit   prev_valid;
        exp_t e;
        prev_valid = 0;
        forever begin
            @(negedge clk);
            #2;
            if (nrst && res_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    e = q[0];
                    if (!prev_valid) chk("latency", cyc - e.acc + 1, e.iters + 2);
                    chk("in_set", in_set, e.ins);
                    chk("iterations", iterations, e.iters);
                    chk("busy_in_done", busy, 0);
                    if (res_ready) void'(q.pop_front());
                end
            end
            prev_valid = res_valid;
        end
    end

    int dir_cr  [9] = '{0,      16'sh2000, 16'sh1000, -16'sh2000, -16'sh1000, 0,  16'sh2000, 16'sh0800, -16'sh0C00};
    int dir_ci  [9] = '{0,      0,         0,         0,          0,          0,  0,         16'sh0800, 16'sh0400};
    int dir_lim [9] = '{10,     255,       255,       50,         50,         0,  0,         30,        40};

    initial begin
        nrst = 1'b0; start = 1'b0; res_ready = 1'b0;
        c_real_in = '0; c_imag_in = '0; z_real_in = '0; z_imag_in = '0; max_iter_in = '0;
        #12;
        chk("rst_start_ready", start_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_in_set", in_set, 0);
        chk("rst_iterations", iterations, 0);
        @(negedge clk);
        nrst = 1'b1;

        // Directed points, including |z|^2 == 4 and zero limit
        for (int i = 0; i < 9; i++) issue(dir_cr[i], dir_ci[i], dir_lim[i], 0, 0, 1'b0);
`ifdef MANDEL_JULIA_EN
        issue(0, 0, 10, 16'sh3000, 0, 1'b0);
        issue(16'sh0400, 16'sh0200, 20, 16'sh0800, -16'sh0800, 1'b0);
`endif
        drain();

        // Random points around the set with random consumer back-pressure
        for (int i = 0; i < 60; i++) begin
            issue(int'($urandom_range(0, 16'h3800)) - 16'sh2800,
                  int'($urandom_range(0, 16'h3000)) - 16'sh1800,
                  int'($urandom_range(0, 40)),
                  int'($urandom_range(0, 16'h2000)) - 16'sh1000,
                  int'($urandom_range(0, 16'h2000)) - 16'sh1000, 1'b0);
        end
        drain();

        // Held result: start ignored while res_ready low, then consume + accept together
        issue(0, 0, 3, 0, 0, 1'b1);
        res_ready = 1'b0;
        for (int n = 0; n < 100 && !res_valid; n++) @(negedge clk);
        chk("hold_valid_seen", res_valid, 1);
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            res_ready   = 1'b0;
            start       = 1'b1;
            c_real_in   = 16'sh2000;
            max_iter_in = 8'd7;
            #1;
            chk("start_ready_held", start_ready, 0);
        end
        issue(16'sh1000, 0, 255, 0, 0, 1'b1);
        chk("busy_after_b2b", busy, 1);
        chk("valid_after_b2b", res_valid, 0);
        drain();

        // Leave a nonzero result in the output registers, then reset mid-job
        issue(-16'sh1000, 0, 50, 0, 0, 1'b1);
        drain();
        issue(0, 0, 200, 0, 0, 1'b1);
        for (int n = 0; n < 20; n++) @(negedge clk);
        chk("busy_before_rst", busy, 1);
        #3;
        nrst = 1'b0;
        #1;
        chk("async_rst_busy", busy, 0);
        chk("async_rst_res_valid", res_valid, 0);
        chk("async_rst_start_ready", start_ready, 1);
        chk("async_rst_in_set", in_set, 0);
        chk("async_rst_iterations", iterations, 0);
        q.delete();
        @(negedge clk);
        nrst = 1'b1;
        issue(-16'sh1000, 0, 50, 0, 0, 1'b0);
        issue(16'sh1000, 0, 255, 0, 0, 1'b0);
        drain();

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mandelbrot_engine.md
MANDELBROT_ENGINE -- requirements
Module: mandelbrot_engine

Interface
REQ-001 SHALL have parameter FIXED_POINT_WIDTH, default 16, meaning signed two's-complement width of every c/z value.
REQ-002 SHALL have parameter FRAC_BITS, default 12, meaning fractional bits of the fixed-point format (Q(W-F).F).
REQ-003 SHALL have parameter ITER_WIDTH, default 8, meaning width of the iteration limit and the iteration count.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port nrst, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1, job request; accepted when start && start_ready.
REQ-007 SHALL have port start_ready, output, 1, high when a job can be accepted.
REQ-008 SHALL have ports c_real_in and c_imag_in, input, FIXED_POINT_WIDTH, signed constant c; sampled on accept.
REQ-009 SHALL have port max_iter_in, input, ITER_WIDTH, unsigned iteration limit; sampled on accept.
REQ-010 SHALL have port busy, output, 1, high while in ITERATE.
REQ-011 SHALL have port res_valid, output, 1, result available (held until consumed).
REQ-012 SHALL have port res_ready, input, 1, consumer accepts the result when res_valid && res_ready.
REQ-013 SHALL have port in_set, output, 1, 1 = limit reached without escape, 0 = escaped.
REQ-014 SHALL have port iterations, output, ITER_WIDTH, count of z updates performed before termination.

Function
REQ-015 SHALL implement FSM IDLE, ITERATE, DONE; start_ready = IDLE || (DONE && res_ready); busy = ITERATE; res_valid = DONE.
REQ-016 On accept: c and limit registered; z = 0 (see REQ-026); count = 0; next state ITERATE.
REQ-017 Each ITERATE cycle, in priority: (a) if zr^2 + zi^2 >= 4.0 -> DONE, in_set = 0; (b) else if count == limit -> DONE, in_set = 1; (c) else z <= z^2 + c, count <= count + 1.
REQ-018 Escape test computed at full precision: squares 2*FIXED_POINT_WIDTH signed, sum 2*FIXED_POINT_WIDTH+1 bits, compared with 4 << (2*FRAC_BITS); no truncation.
REQ-019 z update: zr' = ((zr*zr - zi*zi) >>> FRAC_BITS) + cr; zi' = ((2*zr*zi) >>> FRAC_BITS) + ci; arithmetic shift, then truncated (wrapped) to FIXED_POINT_WIDTH.
REQ-020 Latency accept -> res_valid: iterations + 2 cycles (one ITERATE cycle per update plus the terminating cycle).
REQ-021 in_set and iterations registered on entry to DONE; stable while res_valid is high.
REQ-022 max_iter_in = 0: terminates on first ITERATE cycle, iterations = 0, in_set = 1 unless the escape test already holds.
REQ-023 In DONE with res_ready && start: result consumed and new job accepted in the same cycle, next state ITERATE.
REQ-024 In DONE with res_ready && !start: next state IDLE; start while busy, or in DONE without res_ready, SHALL be ignored.

Reset
REQ-025 nrst low SHALL immediately force IDLE, z = 0, c = 0, count = 0, in_set = 0, iterations = 0, res_valid = 0, busy = 0, start_ready = 1, including mid-ITERATE (job discarded).

Configuration
REQ-026 Macro MANDEL_JULIA_EN: when defined, SHALL add inputs z_real_in, z_imag_in (FIXED_POINT_WIDTH, signed), sampled on accept as initial z (Julia mode); when undefined, ports absent and initial z = 0.

Verification (W=16, F=12, 1.0 = 0x1000)
REQ-027 c = (0,0), max_iter_in = 10 -> res_valid after 12 cycles, iterations = 10, in_set = 1.
REQ-028 c = (2.0,0) = (0x2000,0), limit 255 -> iterations = 1, in_set = 0; c = (1.0,0), limit 255 -> iterations = 2, in_set = 0.
REQ-029 c = (-2.0,0), limit 50 -> iterations = 1, in_set = 0 (|z|^2 = 4.0 counts as escape); c = (-1.0,0), limit 50 -> iterations = 50, in_set = 1.
REQ-030 Back-to-back: res_ready held low 5 cycles after DONE -> outputs stable, start ignored; then res_ready && start in the same cycle -> new job accepted, busy next cycle.
REQ-031 nrst pulsed low in mid-ITERATE of a c = 0, limit 200 job -> all outputs at reset values asynchronously; a new job after release completes normally.
REQ-032 With MANDEL_JULIA_EN: z0 = (3.0,0), c = 0, limit 10 -> iterations = 0, in_set = 0.
